// File: rtl/machine_parser_pkg.sv
// Shared types for the machine-list line parser: ASCII codes, record kinds, FSM states.
package machine_parser_pkg;

  typedef enum logic [7:0] {
    CH_NUL    = 8'h00,
    CH_LF     = 8'h0A,
    CH_SPACE  = 8'h20,
    CH_HASH   = 8'h23,
    CH_LPAREN = 8'h28,
    CH_RPAREN = 8'h29,
    CH_COMMA  = 8'h2C,
    CH_DOT    = 8'h2E,
    CH_0      = 8'h30,
    CH_1      = 8'h31,
    CH_2      = 8'h32,
    CH_3      = 8'h33,
    CH_4      = 8'h34,
    CH_5      = 8'h35,
    CH_6      = 8'h36,
    CH_7      = 8'h37,
    CH_8      = 8'h38,
    CH_9      = 8'h39,
    CH_LBRACK = 8'h5B,
    CH_RBRACK = 8'h5D,
    CH_LBRACE = 8'h7B,
    CH_RBRACE = 8'h7D
  } char_t;

  typedef enum logic [1:0] {
    KIND_LIGHTS  = 2'd0,
    KIND_BUTTON  = 2'd1,
    KIND_JOLTAGE = 2'd2,
    KIND_EOL     = 2'd3
  } kind_t;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LIGHTS = 3'd1;
  localparam state_t S_GAP    = 3'd2;
  localparam state_t S_BUTTON = 3'd3;
  localparam state_t S_JOLT   = 3'd4;
  localparam state_t S_EOF    = 3'd5;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/decimal_accumulator.sv
// Decimal digit accumulator: value = value*10 + digit, saturating at a run-time limit.
module decimal_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] value,
  output logic             overflow
);

  // Four spare bits hold value*10+9 for any WIDTH-bit value.
  logic [WIDTH+3:0] next_wide;

  assign next_wide = {4'b0000, value} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, digit};
  assign overflow  = digit_valid && (next_wide > {4'b0000, limit});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      value <= '0;
    end else if (digit_valid) begin
      value <= overflow ? limit : next_wide[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/machine_line_parser.sv
// Byte-stream decoder for machine lines "[.##.] (3) (1,3) {3,5,4,7}\n" into typed records.
// Define JOLTAGE_DECODE_EN to decode '{...}' into JOLTAGE records; otherwise it is skipped.
module machine_line_parser
  import machine_parser_pkg::*;
#(
  parameter int MAX_WIRING_WIDTH = 16,
  parameter int JOLTAGE_WIDTH    = 10,
  parameter int MAX_ITEMS        = 16,
  localparam int IW              = $clog2(MAX_ITEMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        inbound_valid,
  output logic                        inbound_ready,
  input  logic [7:0]                  inbound_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_kind,
  output logic [IW-1:0]               out_index,
  output logic                        out_last,
  output logic [MAX_WIRING_WIDTH-1:0] out_data,
  output logic                        end_of_file,
  output logic                        format_error,
  output logic [2:0]                  dbg_state
);

  localparam int MW  = MAX_WIRING_WIDTH;
  localparam int LCW = $clog2(MW + 1);
  localparam int AW  = (LCW > JOLTAGE_WIDTH) ? LCW : JOLTAGE_WIDTH;
  localparam logic [IW-1:0] ITEM_LAST = IW'(MAX_ITEMS - 1);

  // Handshakes: a byte moves when inbound_valid & inbound_ready, a record when
  // out_valid & out_ready; out_* are held while out_valid & ~out_ready.

  state_t          state, state_n;
  logic [MW-1:0]   light_mask, light_mask_n;
  logic [LCW-1:0]  light_cnt, light_cnt_n;
  logic [MW-1:0]   btn_mask, btn_mask_n;
  logic [IW-1:0]   btn_cnt, btn_cnt_n;
  logic            btn_full, btn_full_n;
  logic            acc_clear, acc_digit_valid, acc_ovf;
  logic [AW-1:0]   acc_value, acc_limit;
  logic            accept, emit, e_last, err;
  kind_t           e_kind;
  logic [IW-1:0]   e_index;
  logic [MW-1:0]   e_data;
`ifdef JOLTAGE_DECODE_EN
  localparam logic [AW-1:0] JOLT_MAX = AW'((64'd1 << JOLTAGE_WIDTH) - 64'd1);
  logic [IW-1:0]   jolt_cnt, jolt_cnt_n;
  logic            jolt_full, jolt_full_n;
  assign acc_limit = (state == S_JOLT) ? JOLT_MAX : '1;
`else
  assign acc_limit = '1;
`endif

  assign inbound_ready = (state == S_EOF) || !out_valid || out_ready;
  assign accept        = inbound_valid && inbound_ready;
  assign dbg_state     = state;

  decimal_accumulator #(.WIDTH(AW)) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (acc_clear),
    .digit_valid (acc_digit_valid),
    .digit       (inbound_byte[3:0]),
    .limit       (acc_limit),
    .value       (acc_value),
    .overflow    (acc_ovf)
  );

  always_comb begin
    state_n         = state;
    light_mask_n    = light_mask;
    light_cnt_n     = light_cnt;
    btn_mask_n      = btn_mask;
    btn_cnt_n       = btn_cnt;
    btn_full_n      = btn_full;
`ifdef JOLTAGE_DECODE_EN
    jolt_cnt_n      = jolt_cnt;
    jolt_full_n     = jolt_full;
`endif
    acc_clear       = 1'b0;
    acc_digit_valid = 1'b0;
    emit            = 1'b0;
    e_kind          = KIND_EOL;
    e_index         = '0;
    e_last          = 1'b0;
    e_data          = '0;
    err             = 1'b0;
    if (accept && state != S_EOF && inbound_byte != CH_SPACE) begin
      if (inbound_byte == CH_NUL) begin
        state_n = S_EOF;
      end else begin
        case (state)
          S_IDLE: begin
            if (inbound_byte == CH_LBRACK) begin
              state_n      = S_LIGHTS;
              light_mask_n = '0;
              light_cnt_n  = '0;
              btn_cnt_n    = '0;
              btn_full_n   = 1'b0;
`ifdef JOLTAGE_DECODE_EN
              jolt_cnt_n   = '0;
              jolt_full_n  = 1'b0;
`endif
            end else begin
              err = 1'b1;
            end
          end
          S_LIGHTS: begin
            if (inbound_byte == CH_DOT || inbound_byte == CH_HASH) begin
              if (light_cnt < LCW'(MW)) begin
                if (inbound_byte == CH_HASH) light_mask_n = light_mask | (MW'(1) << light_cnt);
                light_cnt_n = light_cnt + LCW'(1);
              end else begin
                err = 1'b1;
              end
            end else if (inbound_byte == CH_RBRACK) begin
              emit    = 1'b1;
              e_kind  = KIND_LIGHTS;
              e_data  = light_mask;
              state_n = S_GAP;
            end else begin
              err = 1'b1;
            end
          end
          S_GAP: begin
            if (inbound_byte == CH_LPAREN) begin
              state_n    = S_BUTTON;
              btn_mask_n = '0;
              acc_clear  = 1'b1;
            end else if (inbound_byte == CH_LBRACE) begin
              state_n   = S_JOLT;
              acc_clear = 1'b1;
            end else if (inbound_byte == CH_LF) begin
              emit       = 1'b1;
              e_kind     = KIND_EOL;
              btn_cnt_n  = '0;
              btn_full_n = 1'b0;
`ifdef JOLTAGE_DECODE_EN
              jolt_cnt_n  = '0;
              jolt_full_n = 1'b0;
`endif
              state_n    = S_IDLE;
            end else begin
              err = 1'b1;
            end
          end
          S_BUTTON: begin
            if (is_digit(inbound_byte)) begin
              acc_digit_valid = 1'b1;
            end else if (inbound_byte == CH_COMMA || inbound_byte == CH_RPAREN) begin
              if (acc_value < AW'(MW)) btn_mask_n = btn_mask | (MW'(1) << acc_value);
              else err = 1'b1;
              acc_clear = 1'b1;
              if (inbound_byte == CH_RPAREN) begin
                emit    = 1'b1;
                e_kind  = KIND_BUTTON;
                e_index = btn_cnt;
                e_data  = btn_mask_n;
                // An item after the counter has wrapped reuses an index.
                if (btn_full) err = 1'b1;
                if (btn_cnt == ITEM_LAST) begin
                  btn_cnt_n  = '0;
                  btn_full_n = 1'b1;
                end else begin
                  btn_cnt_n = btn_cnt + IW'(1);
                end
                state_n = S_GAP;
              end
            end else begin
              err = 1'b1;
            end
          end
          S_JOLT: begin
`ifdef JOLTAGE_DECODE_EN
            if (is_digit(inbound_byte)) begin
              acc_digit_valid = 1'b1;
            end else if (inbound_byte == CH_COMMA || inbound_byte == CH_RBRACE) begin
              emit      = 1'b1;
              e_kind    = KIND_JOLTAGE;
              e_index   = jolt_cnt;
              e_last    = (inbound_byte == CH_RBRACE);
              e_data    = MW'(acc_value);
              acc_clear = 1'b1;
              if (jolt_full) err = 1'b1;
              if (jolt_cnt == ITEM_LAST) begin
                jolt_cnt_n  = '0;
                jolt_full_n = 1'b1;
              end else begin
                jolt_cnt_n = jolt_cnt + IW'(1);
              end
              if (inbound_byte == CH_RBRACE) state_n = S_GAP;
            end else begin
              err = 1'b1;
            end
`else
            if (inbound_byte == CH_RBRACE) state_n = S_GAP;
`endif
          end
          default: state_n = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      light_mask   <= '0;
      light_cnt    <= '0;
      btn_mask     <= '0;
      btn_cnt      <= '0;
      btn_full     <= 1'b0;
`ifdef JOLTAGE_DECODE_EN
      jolt_cnt     <= '0;
      jolt_full    <= 1'b0;
`endif
      out_valid    <= 1'b0;
      out_kind     <= 2'd0;
      out_index    <= '0;
      out_last     <= 1'b0;
      out_data     <= '0;
      end_of_file  <= 1'b0;
      format_error <= 1'b0;
    end else begin
      state      <= state_n;
      light_mask <= light_mask_n;
      light_cnt  <= light_cnt_n;
      btn_mask   <= btn_mask_n;
      btn_cnt    <= btn_cnt_n;
      btn_full   <= btn_full_n;
`ifdef JOLTAGE_DECODE_EN
      jolt_cnt   <= jolt_cnt_n;
      jolt_full  <= jolt_full_n;
`endif
      if (state_n == S_EOF) end_of_file <= 1'b1;
      if (err || acc_ovf) format_error <= 1'b1;
      // emit implies accept, so the register is free or draining this cycle.
      if (emit) begin
        out_valid <= 1'b1;
        out_kind  <= e_kind;
        out_index <= e_index;
        out_last  <= e_last;
        out_data  <= e_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_machine_line_parser.sv
// Directed bench for machine_line_parser; expectations follow JOLTAGE_DECODE_EN when defined.
module tb_machine_line_parser;
  import machine_parser_pkg::*;

  localparam int MW = 16;
  localparam int IW = 4;
  localparam int RW = 2 + IW + 1 + MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          inbound_valid;
  logic          inbound_ready;
  logic [7:0]    inbound_byte;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    out_kind;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic [MW-1:0] out_data;
  logic          end_of_file;
  logic          format_error;
  logic [2:0]    dbg_state;

  int checks = 0;
  int fails  = 0;
  logic [RW-1:0] exp_q[$];

  machine_line_parser dut (
    .clk           (clk),
    .rst           (rst),
    .inbound_valid (inbound_valid),
    .inbound_ready (inbound_ready),
    .inbound_byte  (inbound_byte),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_kind      (out_kind),
    .out_index     (out_index),
    .out_last      (out_last),
    .out_data      (out_data),
    .end_of_file   (end_of_file),
    .format_error  (format_error),
    .dbg_state     (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [RW-1:0] rec(input logic [1:0] k, input logic [IW-1:0] i,
                                        input logic l, input logic [MW-1:0] d);
    return {k, i, l, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard sample sits just before the rising edge; returns at the next falling edge.
  task automatic tick();
    logic [RW-1:0] got;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      got = {out_kind, out_index, out_last, out_data};
      check("record_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("record", 32'(got), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   waited;
    logic took;
    waited        = 0;
    took          = 1'b0;
    inbound_valid = 1'b1;
    inbound_byte  = b;
    while (!took && waited < 20) begin
      took = inbound_ready;
      tick();
      waited++;
    end
    if (!took) check("send_accepted", 32'(took), 32'd1);
    inbound_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    inbound_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    inbound_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    inbound_valid = 1'b0;
    inbound_byte  = 8'h00;
    out_ready     = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_eof", 32'(end_of_file), 32'd0);
    check("rst_format_error", 32'(format_error), 32'd0);
    check("rst_inbound_ready", 32'(inbound_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));

    // basic line with back-to-back records
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0006));
    exp_q.push_back(rec(KIND_BUTTON, 4'd0, 1'b0, 16'h0008));
    exp_q.push_back(rec(KIND_BUTTON, 4'd1, 1'b0, 16'h000A));
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[.##.] (3) (1,3)\n");
    idle(3);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_format_error", 32'(format_error), 32'd0);

    // multi-digit index, then out-of-range index
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0000));
    exp_q.push_back(rec(KIND_BUTTON, 4'd0, 1'b0, 16'h1001));
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[.] (12,0)\n");
    idle(3);
    check("t2a_drained", 32'(exp_q.size()), 32'd0);
    check("t2a_format_error", 32'(format_error), 32'd0);
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0000));
    exp_q.push_back(rec(KIND_BUTTON, 4'd0, 1'b0, 16'h0000));
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[.] (17)\n");
    idle(3);
    check("t2b_drained", 32'(exp_q.size()), 32'd0);
    check("t2b_format_error", 32'(format_error), 32'd1);
    pulse_reset();
    check("t2_reset_clears_error", 32'(format_error), 32'd0);

    // joltage list
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0001));
`ifdef JOLTAGE_DECODE_EN
    exp_q.push_back(rec(KIND_JOLTAGE, 4'd0, 1'b0, 16'd3));
    exp_q.push_back(rec(KIND_JOLTAGE, 4'd1, 1'b0, 16'd5));
    exp_q.push_back(rec(KIND_JOLTAGE, 4'd2, 1'b0, 16'd4));
    exp_q.push_back(rec(KIND_JOLTAGE, 4'd3, 1'b1, 16'd7));
`endif
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[#] {3,5,4,7}\n");
    idle(3);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_format_error", 32'(format_error), 32'd0);

    // backpressure: stall the consumer for five cycles
    out_ready = 1'b0;
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0001));
    exp_q.push_back(rec(KIND_BUTTON, 4'd0, 1'b0, 16'h0001));
    exp_q.push_back(rec(KIND_BUTTON, 4'd1, 1'b0, 16'h0002));
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[#.]");
    inbound_valid = 1'b1;
    inbound_byte  = 8'h20;
    for (int i = 0; i < 5; i++) begin
      check("t4_inbound_ready_low", 32'(inbound_ready), 32'd0);
      check("t4_out_valid_held", 32'(out_valid), 32'd1);
      check("t4_out_kind_held", 32'(out_kind), 32'(KIND_LIGHTS));
      check("t4_out_data_held", 32'(out_data), 32'h0001);
      tick();
    end
    out_ready = 1'b1;
    send_str(" (0) (1)\n");
    idle(3);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a button group
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0000));
    send_str("[.] (1,3");
    idle(3);
    check("t5_partial_drained", 32'(exp_q.size()), 32'd0);
    check("t5_state_button", 32'(dbg_state), 32'(S_BUTTON));
    pulse_reset();
    check("t5_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("t5_out_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0000));
    exp_q.push_back(rec(KIND_BUTTON, 4'd0, 1'b0, 16'h0004));
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[.] (2)\n");
    idle(3);
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_format_error", 32'(format_error), 32'd0);

    // joltage overflow, then end of file
    exp_q.push_back(rec(KIND_LIGHTS, 4'd0, 1'b0, 16'h0000));
`ifdef JOLTAGE_DECODE_EN
    exp_q.push_back(rec(KIND_JOLTAGE, 4'd0, 1'b1, 16'h03FF));
`endif
    exp_q.push_back(rec(KIND_EOL,    4'd0, 1'b0, 16'h0000));
    send_str("[.] {1024}\n");
    idle(3);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
`ifdef JOLTAGE_DECODE_EN
    check("t6_format_error", 32'(format_error), 32'd1);
`else
    check("t6_format_error", 32'(format_error), 32'd0);
`endif
    send_byte(8'h00);
    idle(2);
    check("t6_eof", 32'(end_of_file), 32'd1);
    check("t6_state_eof", 32'(dbg_state), 32'(S_EOF));
    out_ready = 1'b0;
    check("t6_ready_in_eof", 32'(inbound_ready), 32'd1);
    send_str("[#] (1)\n");
    idle(3);
    check("t6_no_record_after_eof", 32'(out_valid), 32'd0);
    check("t6_eof_held", 32'(end_of_file), 32'd1);
    check("t6_ready_held", 32'(inbound_ready), 32'd1);
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
